// File: rtl/uart_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_stream_pkg                                                      |
// | Shared types and constants for the BRAM-to-UART frame streamer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_SEND    = 3'd4,
    ST_CHK     = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;
  localparam int         HDR_BYTES = 7;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_byte                                                         |
// | 8N1 byte serializer; accepts a new byte in the last stop-bit cycle.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_byte
  import uart_stream_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_tx
);

  localparam int               BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int               CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'd9;

  logic             active_q, active_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             baud_tick;

  assign baud_tick = (cnt_q == CNT_LAST);
  // Ready during the final stop-bit cycle so consecutive bytes abut with no idle gap.
  assign tx_ready  = !active_q || ((bit_q == BIT_LAST) && baud_tick);
  assign uart_tx   = tx_q;

  always_comb begin
    active_d = active_q;
    frame_d  = frame_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (tx_valid && tx_ready) begin
      active_d = 1'b1;
      frame_d  = {1'b1, tx_data, 1'b0};
      bit_d    = 4'd0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (baud_tick) begin
        cnt_d = '0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          frame_d = {1'b1, frame_q[9:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    tx_d = active_d ? frame_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      frame_q  <= '1;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_frame_streamer                                                  |
// | Dumps a circular capture buffer as a checksummed 8N1 UART frame.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_frame_streamer
  import uart_stream_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 4,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD_RATE  = 115200,
  parameter logic [7:0] SYNC0      = SYNC0_DEF,
  parameter logic [7:0] SYNC1      = SYNC1_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] trigger_index,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  uart_tx
);

  localparam int                BPS       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [15:0]       CNT_FIELD = 16'(DEPTH - 1'b1);
  localparam logic [2:0]        HDR_LAST  = 3'(HDR_BYTES - 1);
  localparam logic [2:0]        BYTE_LAST = 3'(BPS - 1);

  state_e                  state_q, state_d;
  logic [2:0]              hdr_idx_q, hdr_idx_d;
  logic [2:0]              byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH:0]     smp_cnt_q, smp_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]   trg_q, trg_d;
  logic [DATA_WIDTH-1:0]   samp_q, samp_d;
  logic [7:0]              chk_q, chk_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  logic                    tx_valid;
  logic [7:0]              tx_data;
  logic                    tx_ready;
  logic [7:0]              hdr_byte;
  logic [15:0]             trg16;
  logic                    abort_req;

  assign trg16     = 16'(trg_q);
  assign abort_req = abort_q | abort;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    hdr_byte = 8'(BPS);
    case (hdr_idx_q)
      3'd0:    hdr_byte = SYNC0;
      3'd1:    hdr_byte = SYNC1;
      3'd2:    hdr_byte = CNT_FIELD[15:8];
      3'd3:    hdr_byte = CNT_FIELD[7:0];
      3'd4:    hdr_byte = trg16[15:8];
      3'd5:    hdr_byte = trg16[7:0];
      default: hdr_byte = 8'(BPS);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    byte_idx_d = byte_idx_q;
    smp_cnt_d  = smp_cnt_q;
    rd_addr_d  = rd_addr_q;
    trg_d      = trg_q;
    samp_d     = samp_q;
    chk_d      = chk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    // A short abort pulse is held until the next byte boundary.
    abort_d    = abort_req & busy_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HDR;
          busy_d     = 1'b1;
          rd_addr_d  = base_addr;
          trg_d      = trigger_index - base_addr;
          chk_d      = 8'h00;
          hdr_idx_d  = 3'd0;
          byte_idx_d = 3'd0;
          smp_cnt_d  = '0;
          abort_d    = 1'b0;
        end
      end
      ST_HDR: begin
        if (tx_ready) begin
          if (abort_req && (hdr_idx_q != 3'd0)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            abort_d = 1'b0;
          end else begin
            tx_valid = 1'b1;
            tx_data  = hdr_byte;
            if (hdr_idx_q >= 3'd2) begin
              chk_d = chk_q ^ hdr_byte;
            end
            if (hdr_idx_q == HDR_LAST) begin
              state_d = ST_RD_REQ;
            end else begin
              hdr_idx_d = hdr_idx_q + 3'd1;
            end
          end
        end
      end
      ST_RD_REQ: begin
        state_d   = ST_RD_WAIT;
        rd_addr_d = rd_addr_q + 1'b1;
      end
      ST_RD_WAIT: begin
        samp_d  = rd_data;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (abort_req) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            abort_d = 1'b0;
          end else begin
            tx_valid = 1'b1;
            tx_data  = samp_q[7:0];
            chk_d    = chk_q ^ samp_q[7:0];
            samp_d   = samp_q >> 8;
            if (byte_idx_q == BYTE_LAST) begin
              // Next read is issued while this byte is still on the line.
              byte_idx_d = 3'd0;
              smp_cnt_d  = smp_cnt_q + 1'b1;
              state_d    = ((smp_cnt_q + 1'b1) == DEPTH) ? ST_CHK : ST_RD_REQ;
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
            end
          end
        end
      end
      ST_CHK: begin
        if (tx_ready) begin
          if (abort_req) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            abort_d = 1'b0;
          end else begin
            tx_valid = 1'b1;
            tx_data  = chk_q;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = !abort_req;
          abort_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hdr_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      smp_cnt_q  <= '0;
      rd_addr_q  <= '0;
      trg_q      <= '0;
      samp_q     <= '0;
      chk_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      byte_idx_q <= byte_idx_d;
      smp_cnt_q  <= smp_cnt_d;
      rd_addr_q  <= rd_addr_d;
      trg_q      <= trg_d;
      samp_q     <= samp_d;
      chk_q      <= chk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  uart_tx_byte #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .uart_tx  (uart_tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_frame_streamer                                               |
// | Two streamer instances (8-bit and 16-bit samples) vs a frame model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_frame_streamer;

  localparam int DIV_A = 5;   // 50 MHz / 10 MBd
  localparam int DIV_B = 7;   // 50 MHz / 7 MBd, truncated

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [3:0]  base_a, trig_a, base_b, trig_b;
  logic        busy_a, done_a, tx_a, busy_b, done_b, tx_b;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a;
  logic [15:0] rd_data_b;
  logic [7:0]  mem_a [16];
  logic [15:0] mem_b [16];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          sel = 1'b0;
  wire         line = sel ? tx_b : tx_a;
  int          done_cnt_a = 0, done_cnt_b = 0, done_cyc = 0;
  int          exp_done_a = 0, exp_done_b = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          tim_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data_a <= mem_a[rd_addr_a];
  always @(posedge clk) rd_data_b <= mem_b[rd_addr_b];

  uart_frame_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLK_FREQ(50_000_000),
                        .BAUD_RATE(10_000_000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .base_addr(base_a),
    .trigger_index(trig_a), .busy(busy_a), .done(done_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .uart_tx(tx_a));

  uart_frame_streamer #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLK_FREQ(50_000_000),
                        .BAUD_RATE(7_000_000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .base_addr(base_b),
    .trigger_index(trig_b), .busy(busy_b), .done(done_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .uart_tx(tx_b));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      if (!sel) done_cyc = cyc;
      chk_eq("busy_at_done_a", 32'(busy_a), 32'd0);
    end
    if (done_b) begin
      done_cnt_b++;
      if (sel) done_cyc = cyc;
      chk_eq("busy_at_done_b", 32'(busy_b), 32'd0);
    end
  end

  // Expected frame built directly from the frame layout rules.
  task automatic build_model(input bit s, input int base, input int trig);
    int depth, bps, trg, a;
    logic [15:0] v;
    logic [7:0]  x;
    depth = 16;
    bps   = s ? 2 : 1;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'((depth - 1) >> 8));
    exp_q.push_back(8'(depth - 1));
    trg = (((trig - base) % depth) + depth) % depth;
    exp_q.push_back(8'(trg >> 8));
    exp_q.push_back(8'(trg));
    exp_q.push_back(8'(bps));
    for (int i = 0; i < depth; i++) begin
      a = (base + i) % depth;
      v = s ? mem_b[a] : {8'h00, mem_a[a]};
      for (int k = 0; k < bps; k++) exp_q.push_back(8'(v >> (8 * k)));
    end
    x = 8'h00;
    for (int i = 2; i < exp_q.size(); i++) x = x ^ exp_q[i];
    exp_q.push_back(x);
  endtask

  task automatic set_abort(input logic v);
    if (sel) abort_b = v; else abort_a = v;
  endtask

  task automatic pulse_start(input int base, input int trig, output int t_drive);
    @(posedge clk); #1;
    if (sel) begin base_b = 4'(base); trig_b = 4'(trig); start_b = 1'b1; end
    else     begin base_a = 4'(base); trig_a = 4'(trig); start_a = 1'b1; end
    t_drive = cyc;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    base_a = 4'($urandom); trig_a = 4'($urandom);
    base_b = 4'($urandom); trig_b = 4'($urandom);
  endtask

  task automatic rx_byte(output logic [7:0] b, output int t, output bit ok,
                         input int tmo, input bit do_abort);
    int d;
    d  = sel ? DIV_B : DIV_A;
    ok = 1'b0; b = 8'h00; t = 0;
    for (int i = 0; i < tmo; i++) begin
      @(posedge clk); #1;
      if (line === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    t = cyc;
    if (do_abort) set_abort(1'b1);
    @(posedge clk); #1;
    set_abort(1'b0);
    repeat (d / 2 - 1) @(posedge clk);
    #1;
    chk_eq("start_bit", 32'(line), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (d) @(posedge clk);
      #1;
      b[k] = line;
    end
    repeat (d) @(posedge clk);
    #1;
    chk_eq("stop_bit", 32'(line), 32'd1);
  endtask

  task automatic rx_frame(input int abort_idx);
    logic [7:0] b;
    int t, d;
    bit ok;
    d = sel ? DIV_B : DIV_A;
    got_q.delete();
    tim_q.delete();
    for (int i = 0; i < 64; i++) begin
      rx_byte(b, t, ok, (i == 0) ? 20 : 3 * d, i == abort_idx);
      if (!ok) break;
      got_q.push_back(b);
      tim_q.push_back(t);
    end
  endtask

  task automatic check_frame(input string tag, input int nexp);
    int d, n;
    d = sel ? DIV_B : DIV_A;
    chk_eq({tag, "_len"}, 32'(got_q.size()), 32'(nexp));
    n = (got_q.size() < nexp) ? got_q.size() : nexp;
    for (int i = 0; i < n; i++) begin
      chk_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      if (i > 0) chk_eq($sformatf("%s_gap%0d", tag, i), 32'(tim_q[i] - tim_q[i-1]), 32'(10 * d));
    end
  endtask

  task automatic full_frame(input string tag, input int base, input int trig);
    int td, n;
    build_model(sel, base, trig);
    n = exp_q.size();
    pulse_start(base, trig, td);
    rx_frame(-1);
    check_frame(tag, n);
    if (got_q.size() == n) begin
      chk_eq({tag, "_latency"}, 32'(tim_q[0] - td <= 2), 32'd1);
      chk_eq({tag, "_done_time"}, 32'(done_cyc), 32'(tim_q[n-1] + 10 * (sel ? DIV_B : DIV_A)));
    end
    if (sel) exp_done_b++; else exp_done_a++;
    chk_eq({tag, "_done_cnt"}, 32'(sel ? done_cnt_b : done_cnt_a), 32'(sel ? exp_done_b : exp_done_a));
    chk_eq({tag, "_busy_end"}, 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int t, td;
    bit ok;

    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; base_a = '0; trig_a = '0;
    start_b = 1'b0; abort_b = 1'b0; base_b = '0; trig_b = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = {8'(i), ~8'(i)};
    end
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_tx_a",   32'(tx_a),      32'd1);
    chk_eq("rst_busy_a", 32'(busy_a),    32'd0);
    chk_eq("rst_done_a", 32'(done_a),    32'd0);
    chk_eq("rst_addr_a", 32'(rd_addr_a), 32'd0);
    chk_eq("rst_tx_b",   32'(tx_b),      32'd1);
    chk_eq("rst_busy_b", 32'(busy_b),    32'd0);
    rst_n = 1'b1;

    // abort while idle does nothing
    sel = 1'b0;
    @(posedge clk); #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    chk_eq("idle_abort_busy", 32'(busy_a), 32'd0);
    rx_byte(b, t, ok, 20, 1'b0);
    chk_eq("idle_abort_line", 32'(ok), 32'd0);

    full_frame("ramp", 0, 6);

    // wrap, with a second start pulsed mid-frame that must be ignored
    build_model(1'b0, 10, 6);
    pulse_start(10, 6, td);
    fork
      rx_frame(-1);
      begin
        repeat (300) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
      end
    join
    check_frame("wrap", 24);
    exp_done_a++;
    chk_eq("wrap_done_cnt", 32'(done_cnt_a), 32'(exp_done_a));
    rx_byte(b, t, ok, 40, 1'b0);
    chk_eq("wrap_no_requeue", 32'(ok), 32'd0);

    sel = 1'b1;
    full_frame("wide", 0, 0);

    // abort during payload byte 3 (frame byte 10)
    sel = 1'b0;
    build_model(1'b0, 3, 9);
    pulse_start(3, 9, td);
    rx_frame(10);
    check_frame("abort", 11);
    chk_eq("abort_busy", 32'(busy_a), 32'd0);
    chk_eq("abort_no_done", 32'(done_cnt_a), 32'(exp_done_a));
    chk_eq("abort_line_idle", 32'(tx_a), 32'd1);
    full_frame("after_abort", 5, 2);

    // reset in the middle of a start bit
    build_model(1'b0, 7, 1);
    pulse_start(7, 1, td);
    rx_byte(b, t, ok, 20, 1'b0);
    chk_eq("rst_sync0", 32'(b), 32'h0A5);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tx_a === 1'b0) begin ok = 1'b1; break; end
    end
    chk_eq("rst_found_low", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_mid_tx",   32'(tx_a),   32'd1);
    chk_eq("rst_mid_busy", 32'(busy_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_byte(b, t, ok, 40, 1'b0);
    chk_eq("rst_no_resume", 32'(ok), 32'd0);
    full_frame("after_rst", 7, 1);

    // randomized frames on both instances
    for (int r = 0; r < 4; r++) begin
      sel = (r == 3);
      for (int i = 0; i < 16; i++) begin
        mem_a[i] = 8'($urandom);
        mem_b[i] = 16'($urandom);
      end
      full_frame($sformatf("rand%0d", r), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_streamer.md
Name: uart_frame_streamer

Overview:
Next-generation BRAM-to-UART capture dumper for the logic analyzer.
- Streams a full circular capture buffer out over 8N1 UART as a self-describing frame: sync word, sample count, trigger position, bytes per sample, payload and XOR checksum.
- Generalised to sample widths that are any multiple of 8 bits, with a circular read start (oldest sample first) and an abort request.
- Sits between the sample_buffer read port and the board UART TX pin.

Parameters:
- DATA_WIDTH, 8, sample width in bits; must be a multiple of 8, range 8..32.
- ADDR_WIDTH, 4, buffer address width; DEPTH = 2^ADDR_WIDTH; range 1..16.
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, UART bit rate.
- SYNC0, 8'hA5, first sync byte.
- SYNC1, 8'h5A, second sync byte.

Ports:
- clk, in, 1, single system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to send a frame; ignored while busy.
- abort, in, 1, level or pulse; ends the frame early at the next byte boundary.
- base_addr, in, ADDR_WIDTH, address of the oldest sample (first one sent).
- trigger_index, in, ADDR_WIDTH, absolute buffer address of the trigger sample.
- busy, out, 1, high from the cycle after an accepted start until the frame ends.
- done, out, 1, one-cycle pulse after the checksum stop bit; not pulsed on abort.
- rd_addr, out, ADDR_WIDTH, BRAM read address.
- rd_data, in, DATA_WIDTH, BRAM read data; 1-cycle registered latency.
- uart_tx, out, 1, serial line; idles high.

Behaviour:
- Reset values: uart_tx=1, busy=0, done=0, rd_addr=0, all counters 0, state IDLE. Reset mid-byte forces the line high immediately.
- Bit timing: BAUD_DIV = CLK_FREQ/BAUD_RATE, truncated; each bit lasts BAUD_DIV clocks.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Bytes are sent back-to-back with no idle gap.
- BPS = DATA_WIDTH/8.
- On start in IDLE: latch base_addr and trigger_index, clear the checksum, set busy on the next edge, and drive the start bit of SYNC0 within 2 cycles.
- Frame byte order:
  - SYNC0, SYNC1.
  - CNT_H, CNT_L = DEPTH-1 as 16 bits, big-endian.
  - TRG_H, TRG_L = (trigger_index - base_addr) mod DEPTH, zero-extended to 16 bits, big-endian.
  - BPS.
  - Payload: DEPTH samples starting at base_addr, incrementing with wrap modulo DEPTH; each sample sent little-endian, byte 0 = rd_data[7:0].
  - CHK.
- CHK = XOR of every byte from CNT_H through the last payload byte. Sync bytes are excluded.
- States and transitions:
  - IDLE -> HDR on start.
  - HDR sends 7 header bytes, then goes to RD_REQ.
  - RD_REQ drives rd_addr, then RD_WAIT.
  - RD_WAIT captures rd_data into the sample shift register, then SEND.
  - SEND emits BPS bytes. After the last byte, go to RD_REQ if samples remain, else CHK.
  - CHK sends the checksum byte, then DONE.
  - DONE pulses done for 1 cycle, clears busy, returns to IDLE.
- Sample prefetch: the next sample's BRAM read is issued during the current sample's last byte, so no gap appears on the line.
- Sample counter is ADDR_WIDTH+1 bits wide, so DEPTH=65536 is handled.
- abort:
  - The current byte completes, including its stop bit.
  - The block then returns to IDLE, clears busy and does not pulse done.
  - abort in IDLE has no effect.
- start together with abort in IDLE: start wins. abort is evaluated only at byte boundaries.
- start while busy: ignored, not queued.
- The base_addr and trigger_index inputs may change after start without affecting the frame in progress.

Decomposition:
- Shared package uart_stream_pkg holds:
  - state enumeration;
  - SYNC default constants;
  - BAUD_DIV derivation function;
  - header length constant HDR_BYTES = 7.
- One sub-module, uart_tx_byte, is natural:
  - inputs: tx_valid, tx_data[7:0];
  - output: tx_ready, high when it can accept a byte;
  - drives uart_tx;
  - parameters CLK_FREQ and BAUD_RATE.
- The parent FSM handles sequencing, address wrap, prefetch and checksum.

Test Plan:
- Ramp, no wrap: DATA_WIDTH=8, ADDR_WIDTH=4, RAM[i]=i, base 0, trigger 6 -> bytes A5 5A 00 0F 00 06 01 00..0F 08; done pulses once; busy drops the same cycle.
- Wrap: base 10, trigger 6 -> trigger field 00 0C; payload 0A..0F then 00..09; CHK 02.
- Wide samples: DATA_WIDTH=16, RAM[i]={i,~i}, base 0, trigger 0 -> BPS 02; sample 1 sent as FE 01; total 7+32+1 = 40 bytes; CHK equals a bench-computed XOR.
- Timing: at 50 MHz / 115200, every bit is 434 clocks, and the start bit of byte n+1 immediately follows the stop bit of byte n.
- Abort during payload byte 3 -> that byte completes, line idles high, busy clears after the stop bit, done never pulses; a later start sends a full frame.
- start pulsed while busy and reset asserted mid-frame -> second start ignored; on reset, uart_tx=1 immediately and busy=0; a fresh start after reset sends a clean frame.
